// File: rtl/ws2812_frame_sequencer.sv
`timescale 1ns/1ps
// WS2812 frame sequencer: loads a 24-bit colour register, walks 24*NUM_LEDS bits with rotate pulses, then holds the latch low.
// All outputs are registered; dout trails the bit tick by one cycle; go is only honoured while idle.
module ws2812_frame_sequencer #(
  parameter int NUM_LEDS = 8,
  parameter int T0H      = 40,
  parameter int T1H      = 80,
  parameter int TBIT     = 125,
  parameter int TRES     = 5000
) (
  input  logic clk,
  input  logic reset,
  input  logic go,
  input  logic CurrentBit,
  output logic LoadRegister,
  output logic RotateRegisterLeft,
  output logic dout,
  output logic busy,
  output logic done
);
  localparam int NBITS = 24 * NUM_LEDS;
  localparam int TMAX  = (TBIT > TRES) ? TBIT : TRES;
  localparam int TW    = $clog2(TMAX + 1);
  localparam int CW    = $clog2(NBITS + 1);

  localparam logic [TW-1:0] TICK_BIT_END = TW'(TBIT - 1);
  localparam logic [TW-1:0] TICK_RES_END = TW'(TRES - 1);
  localparam logic [TW-1:0] HI0          = TW'(T0H);
  localparam logic [TW-1:0] HI1          = TW'(T1H);
  localparam logic [CW-1:0] LAST_BIT     = CW'(NBITS - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_BIT, S_LATCH} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [TW-1:0] r_tick;
  logic [TW-1:0] w_tick_nxt;
  logic [CW-1:0] r_bit_cnt;
  logic [CW-1:0] w_bit_cnt_nxt;
  logic          r_bit_q;
  logic          w_bit;
  logic          r_load;
  logic          r_rot;
  logic          r_dout;
  logic          r_busy;
  logic          r_done;

  // The colour bit is taken live on tick 0 and held for the rest of the period.
  assign w_bit = (r_tick == '0) ? CurrentBit : r_bit_q;

  always_comb begin
    w_state_nxt   = r_state;
    w_tick_nxt    = r_tick;
    w_bit_cnt_nxt = r_bit_cnt;
    case (r_state)
      S_IDLE: begin
        if (go) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        w_state_nxt   = S_BIT;
        w_tick_nxt    = '0;
        w_bit_cnt_nxt = '0;
      end
      S_BIT: begin
        if (r_tick == TICK_BIT_END) begin
          w_tick_nxt    = '0;
          w_bit_cnt_nxt = r_bit_cnt + CW'(1);
          if (r_bit_cnt == LAST_BIT) w_state_nxt = S_LATCH;
        end else begin
          w_tick_nxt = r_tick + TW'(1);
        end
      end
      S_LATCH: begin
        if (r_tick == TICK_RES_END) begin
          w_state_nxt = S_IDLE;
          w_tick_nxt  = '0;
        end else begin
          w_tick_nxt = r_tick + TW'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Pulses are decoded from the next state so each lines up with the state it describes;
  // rotate lands on the last tick so the register has advanced by the next tick 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_tick    <= '0;
      r_bit_cnt <= '0;
      r_bit_q   <= 1'b0;
      r_load    <= 1'b0;
      r_rot     <= 1'b0;
      r_dout    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_tick    <= w_tick_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      if (r_state == S_BIT && r_tick == '0) r_bit_q <= CurrentBit;
      r_load <= (w_state_nxt == S_LOAD);
      r_busy <= (w_state_nxt != S_IDLE);
      r_rot  <= (w_state_nxt == S_BIT) && (w_tick_nxt == TICK_BIT_END);
      r_done <= (w_state_nxt == S_LATCH) && (w_tick_nxt == TICK_RES_END);
      r_dout <= (r_state == S_BIT) && (r_tick < (w_bit ? HI1 : HI0));
    end
  end

  assign LoadRegister       = r_load;
  assign RotateRegisterLeft = r_rot;
  assign dout               = r_dout;
  assign busy               = r_busy;
  assign done               = r_done;

  a_legal_params: assert property (@(posedge clk)
    (T0H > 0) && (T0H < T1H) && (T1H < TBIT) && (TRES >= 1) && (NUM_LEDS >= 1));

endmodule
